// File: rtl/cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_arbiter
// Purpose  : Shared miss handler for the I-cache and D-cache. Picks one
//            pending miss (alternating on a tie) and fills one 16-byte block,
//            which is 8 x 16-bit words, from the shared multi-cycle memory.
//            It writes each word into the owning cache's data array, then
//            issues one tag-array write that commits the block.
// Ports    : clk, rst_n                       clock, sync active-low reset
//            icache_miss/_addr                I-cache miss request
//            dcache_miss/_addr                D-cache miss request
//            memory_data_valid/_in            memory read return
//            memory_enable/_address           memory read request
//            fill_data, fill_addr             data/address for owning cache
//            i_/d_data_wr, i_/d_write_tag_array  per-cache write strobes
//            fsm_busy, owner_is_d             status
// Revision : 1.0 - initial release
// ============================================================================
module cache_fill_arbiter #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icache_miss,
  input  logic [ADDR_WIDTH-1:0] icache_miss_addr,
  input  logic                  dcache_miss,
  input  logic [ADDR_WIDTH-1:0] dcache_miss_addr,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data_in,
  output logic                  memory_enable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [15:0]           fill_data,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic                  i_data_wr,
  output logic                  i_write_tag_array,
  output logic                  d_data_wr,
  output logic                  d_write_tag_array,
  output logic                  fsm_busy,
  output logic                  owner_is_d
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_block_mask = ~{{(ADDR_WIDTH-4){1'b0}}, 4'hF};
  localparam logic [3:0]            c_words      = 4'd8;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_owner;       // 1 = D-cache owns the fill
  logic                  r_last_grant;  // 1 = D-cache was granted last
  logic [3:0]            r_issue_cnt;
  logic [3:0]            r_rx_cnt;

  logic                  w_grant;
  logic                  w_grant_d;
  logic [ADDR_WIDTH-1:0] w_grant_addr;
  logic                  w_issue;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_issue_off;
  logic [ADDR_WIDTH-1:0] w_rx_off;

  // Word counters become byte offsets (word index * 2).
  assign w_issue_off = {{(ADDR_WIDTH-5){1'b0}}, r_issue_cnt, 1'b0};
  assign w_rx_off    = {{(ADDR_WIDTH-5){1'b0}}, r_rx_cnt, 1'b0};

  always_comb begin
    w_grant      = 1'b0;
    w_grant_d    = 1'b0;
    w_grant_addr = icache_miss_addr;
    w_issue      = 1'b0;
    w_accept     = 1'b0;
    w_next_state = r_state;

    if (r_state == S_IDLE) begin
      w_grant = icache_miss | dcache_miss;
      // On a tie, serve whichever cache was not granted last time.
      if (icache_miss && dcache_miss) begin
        w_grant_d = ~r_last_grant;
      end else begin
        w_grant_d = dcache_miss;
      end
    end
    if (w_grant_d) begin
      w_grant_addr = dcache_miss_addr;
    end

    if (r_state == S_FILL) begin
      w_issue  = (r_issue_cnt < c_words);
      w_accept = memory_data_valid && (r_rx_cnt < c_words);
    end

    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_next_state = S_FILL;
        end
      end
      S_FILL: begin
        if (w_accept && (r_rx_cnt == c_words - 4'd1)) begin
          w_next_state = S_COMMIT;
        end
      end
      S_COMMIT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;  // first simultaneous miss goes to the I-cache
      r_issue_cnt  <= 4'd0;
      r_rx_cnt     <= 4'd0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_base       <= w_grant_addr & c_block_mask;
        r_owner      <= w_grant_d;
        r_last_grant <= w_grant_d;
        r_issue_cnt  <= 4'd0;
        r_rx_cnt     <= 4'd0;
      end else begin
        if (w_issue) begin
          r_issue_cnt <= r_issue_cnt + 4'd1;
        end
        if (w_accept) begin
          r_rx_cnt <= r_rx_cnt + 4'd1;
        end
      end
    end
  end

  assign memory_enable  = w_issue;
  assign memory_address = w_issue ? (r_base + w_issue_off) : '0;

  always_comb begin
    fill_addr = '0;
    case (r_state)
      S_FILL:   fill_addr = r_base + w_rx_off;
      S_COMMIT: fill_addr = r_base;
      default:  fill_addr = '0;
    endcase
  end

  // Data path and data strobes follow the memory return combinationally so
  // the word lands in the cache in the same cycle it is valid.
  assign fill_data         = memory_data_in;
  assign i_data_wr         = w_accept & ~r_owner;
  assign d_data_wr         = w_accept &  r_owner;
  assign i_write_tag_array = (r_state == S_COMMIT) & ~r_owner;
  assign d_write_tag_array = (r_state == S_COMMIT) &  r_owner;
  assign fsm_busy          = (r_state != S_IDLE);
  assign owner_is_d        = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_fill_arbiter
// Purpose  : Self-checking bench for cache_fill_arbiter. A latency-4 memory
//            model answers the DUT's reads; expected requests, data writes
//            and tag commits are queued when a miss is posted and compared
//            as the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_fill_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_miss = 1'b0;
  logic [15:0] icache_miss_addr = 16'h0;
  logic        dcache_miss = 1'b0;
  logic [15:0] dcache_miss_addr = 16'h0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data_in = 16'h0;
  logic        memory_enable;
  logic [15:0] memory_address;
  logic [15:0] fill_data;
  logic [15:0] fill_addr;
  logic        i_data_wr, i_write_tag_array, d_data_wr, d_write_tag_array;
  logic        fsm_busy, owner_is_d;

  cache_fill_arbiter #(.ADDR_WIDTH(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .icache_miss       (icache_miss),
    .icache_miss_addr  (icache_miss_addr),
    .dcache_miss       (dcache_miss),
    .dcache_miss_addr  (dcache_miss_addr),
    .memory_data_valid (memory_data_valid),
    .memory_data_in    (memory_data_in),
    .memory_enable     (memory_enable),
    .memory_address    (memory_address),
    .fill_data         (fill_data),
    .fill_addr         (fill_addr),
    .i_data_wr         (i_data_wr),
    .i_write_tag_array (i_write_tag_array),
    .d_data_wr         (d_data_wr),
    .d_write_tag_array (d_write_tag_array),
    .fsm_busy          (fsm_busy),
    .owner_is_d        (owner_is_d)
  );

  always #5 clk = ~clk;

  typedef struct { logic d; logic [15:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic [15:0] addr; int cyc; } req_t;
  typedef struct { logic d; logic [15:0] base; int cyc; } tag_t;
  typedef struct { logic [15:0] data; int due; } mem_t;

  wr_t  exp_wr[$];
  req_t exp_req[$];
  tag_t exp_tag[$];
  mem_t mem_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr_cyc = -100;
  int rx_seen = 0;
  bit gap_mode = 1'b0;
  bit force_valid = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a ^ 16'h5A3C) + 16'h0101;
  endfunction

  // Expected traffic for one full block fill granted in cycle gcyc.
  task automatic push_fill(input logic d, input logic [15:0] addr, input int gcyc, input bit timed);
    logic [15:0] base;
    logic [15:0] a;
    base = addr & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(2 * k);
      exp_req.push_back('{addr: a, cyc: gcyc + 1 + k});
      exp_wr.push_back('{d: d, addr: a, data: mem_word(a)});
    end
    exp_tag.push_back('{d: d, base: base, cyc: timed ? gcyc + 13 : -1});
  endtask

  // One clock: drive memory return, compare DUT activity, record requests.
  task automatic tick();
    wr_t  w;
    req_t r;
    tag_t t;
    @(posedge clk);
    cyc++;
    #1;
    memory_data_valid = 1'b0;
    memory_data_in    = 16'h0;
    if (force_valid) begin
      memory_data_valid = 1'b1;
      memory_data_in    = 16'hDEAD;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc &&
                 !(gap_mode && $urandom_range(0, 1) == 0)) begin
      memory_data_valid = 1'b1;
      memory_data_in    = mem_q[0].data;
      void'(mem_q.pop_front());
    end
    #1;
    if (i_data_wr || d_data_wr) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_data_wr cyc=%0d i=%b d=%b fill_addr=%h required none", cyc, i_data_wr, d_data_wr, fill_addr);
      end else begin
        w = exp_wr.pop_front();
        if ({i_data_wr, d_data_wr, owner_is_d, fill_addr, fill_data} !== {~w.d, w.d, w.d, w.addr, w.data}) begin
          errors++;
          $display("FAIL data_wr cyc=%0d got i=%b d=%b own=%b addr=%h data=%h required d=%b addr=%h data=%h",
                   cyc, i_data_wr, d_data_wr, owner_is_d, fill_addr, fill_data, w.d, w.addr, w.data);
        end
      end
      last_wr_cyc = cyc;
      rx_seen++;
    end
    if (memory_enable) begin
      checks++;
      if (exp_req.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mem_req cyc=%0d addr=%h required none", cyc, memory_address);
      end else begin
        r = exp_req.pop_front();
        if (memory_address !== r.addr || cyc != r.cyc) begin
          errors++;
          $display("FAIL mem_req got addr=%h cyc=%0d required addr=%h cyc=%0d", memory_address, cyc, r.addr, r.cyc);
        end
      end
      mem_q.push_back('{data: mem_word(memory_address), due: cyc + LAT});
    end
    if (i_write_tag_array || d_write_tag_array) begin
      checks++;
      if (exp_tag.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tag_wr cyc=%0d i=%b d=%b required none", cyc, i_write_tag_array, d_write_tag_array);
      end else begin
        t = exp_tag.pop_front();
        if ({i_write_tag_array, d_write_tag_array, fill_addr, fsm_busy} !== {~t.d, t.d, t.base, 1'b1} ||
            cyc != last_wr_cyc + 1 || (t.cyc >= 0 && cyc != t.cyc)) begin
          errors++;
          $display("FAIL tag_wr got i=%b d=%b addr=%h busy=%b cyc=%0d required d=%b addr=%h cyc=%0d (last wr %0d)",
                   i_write_tag_array, d_write_tag_array, fill_addr, fsm_busy, cyc, t.d, t.base, t.cyc, last_wr_cyc);
        end
        // The commit clears the cache's miss latch.
        if (t.d) dcache_miss = 1'b0;
        else     icache_miss = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (exp_tag.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_tag.size() != 0 || exp_req.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL %s_incomplete pending tag=%0d req=%0d wr=%0d required 0 0 0", name, exp_tag.size(), exp_req.size(), exp_wr.size());
      exp_tag.delete(); exp_req.delete(); exp_wr.delete();
    end
    tick();
    checks++;
    if (fsm_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle fsm_busy=%b required 0", name, fsm_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      force_valid = (k >= 2);
      tick();
      checks++;
      if ({memory_enable, memory_address, fill_addr, i_data_wr, d_data_wr,
           i_write_tag_array, d_write_tag_array, fsm_busy, owner_is_d} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d en=%b maddr=%h faddr=%h iwr=%b dwr=%b itag=%b dtag=%b busy=%b own=%b required all 0",
                 cyc, memory_enable, memory_address, fill_addr, i_data_wr, d_data_wr,
                 i_write_tag_array, d_write_tag_array, fsm_busy, owner_is_d);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({i_data_wr, d_data_wr, fsm_busy} !== 3'b000) begin
        errors++;
        $display("FAIL idle_valid_ignored iwr=%b dwr=%b busy=%b required 0 0 0", i_data_wr, d_data_wr, fsm_busy);
      end
    end
    force_valid = 1'b0;
    tick();
  endtask

  task automatic test_d_single();
    dcache_miss_addr = 16'h1236;
    dcache_miss = 1'b1;
    push_fill(1'b1, 16'h1236, cyc, 1'b1);
    wait_done("d_single", 40);
  endtask

  task automatic test_back_to_back();
    for (int rep = 0; rep < 2; rep++) begin
      icache_miss_addr = (rep == 0) ? 16'h2468 : 16'h7A02;
      dcache_miss_addr = (rep == 0) ? 16'h9BCE : 16'h0010;
      icache_miss = 1'b1;
      dcache_miss = 1'b1;
      push_fill(1'b0, icache_miss_addr, cyc, 1'b1);
      push_fill(1'b1, dcache_miss_addr, cyc + 14, 1'b1);
      wait_done("back_to_back", 60);
    end
  endtask

  task automatic test_gaps();
    gap_mode = 1'b1;
    icache_miss_addr = 16'h4A5C;
    icache_miss = 1'b1;
    push_fill(1'b0, 16'h4A5C, cyc, 1'b0);
    wait_done("gaps", 200);
    gap_mode = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    int n = 0;
    rx_seen = 0;
    icache_miss_addr = 16'h0ABC;
    icache_miss = 1'b1;
    push_fill(1'b0, 16'h0ABC, cyc, 1'b1);
    while (rx_seen < 3 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (rx_seen != 3) begin
      errors++;
      $display("FAIL mid_fill_words got %0d required 3", rx_seen);
    end
    rst_n = 1'b0;
    icache_miss = 1'b0;
    exp_req.delete(); exp_wr.delete(); exp_tag.delete();
    tick();
    rst_n = 1'b1;
    checks++;
    if (fsm_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_fill_reset_idle fsm_busy=%b required 0", fsm_busy);
    end
    // Stale returns still in flight arrive here and must be ignored.
    repeat (8) tick();
    mem_q.delete();
    icache_miss = 1'b1;
    push_fill(1'b0, 16'h0ABC, cyc, 1'b1);
    wait_done("restart", 40);
  endtask

  task automatic test_wrap();
    dcache_miss_addr = 16'hFFF8;
    dcache_miss = 1'b1;
    push_fill(1'b1, 16'hFFF8, cyc, 1'b1);
    wait_done("wrap", 40);
  endtask

  initial begin
    test_reset();
    test_d_single();
    test_back_to_back();
    test_gaps();
    test_reset_mid_fill();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Miss-handling controller shared by the instruction and data caches. It arbitrates between simultaneous I-cache and D-cache misses and sequences one 16-byte block fill (8 × 16-bit words) from the shared multi-cycle main memory. It drives each cache's data-array writes word by word, then issues a single tag-array write that commits the block and clears that cache's miss latch. It sits between the two cache instances and the memory module, in place of a per-cache fill FSM.

## Interface
- ADDR_WIDTH, 16, byte-address width; block = 16 bytes, offset = addr[3:0]
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- icache_miss  input  1  I-cache miss_detected
- icache_miss_addr  input  ADDR_WIDTH  I-cache missing address
- dcache_miss  input  1  D-cache miss_detected
- dcache_miss_addr  input  ADDR_WIDTH  D-cache missing address
- memory_data_valid  input  1  memory read data valid this cycle
- memory_data_in  input  16  memory read data
- memory_enable  output  1  memory read request, one word per cycle
- memory_address  output  ADDR_WIDTH  word address of the read request
- fill_data  output  16  data for cache data_in; equals memory_data_in
- fill_addr  output  ADDR_WIDTH  address to present to the owning cache's addr port
- i_data_wr / i_write_tag_array  output  1 each  I-cache write strobes
- d_data_wr / d_write_tag_array  output  1 each  D-cache write strobes
- fsm_busy  output  1  fill in progress (any state other than IDLE)
- owner_is_d  output  1  current or last grant: 1 = D-cache, 0 = I-cache

## Operation
- States: IDLE, FILL, COMMIT.
- Registers:
  - base: block address, = miss_addr & ~16'h000F
  - owner
  - last_grant
  - issue_cnt: 4-bit, 0..8
  - rx_cnt: 4-bit, 0..8
- IDLE: grant rules, evaluated each cycle.
  - Only one miss high: grant it.
  - Both high: grant the cache not equal to last_grant.
  - On grant: latch base and owner, set last_grant = owner, clear both counters, go to FILL.
  - No miss: stay in IDLE.
- FILL, issue side:
  - While issue_cnt < 8: memory_enable = 1, memory_address = base + 2·issue_cnt, issue_cnt increments.
  - After 8 issues: memory_enable = 0.
- FILL, receive side:
  - Each cycle with memory_data_valid = 1 and rx_cnt < 8: owner's data_wr = 1, fill_addr = base + 2·rx_cnt, fill_data = memory_data_in, rx_cnt increments.
  - When the 8th word is accepted: go to COMMIT.
- Address presented to the owning cache:
  - fill_addr = base + 2·rx_cnt in FILL.
  - fill_addr = base in COMMIT.
  - Upper system muxes fill_addr onto that cache's addr whenever fsm_busy && owner selects it.
- COMMIT: exactly one cycle.
  - Owner's write_tag_array = 1, fill_addr = base.
  - Next state IDLE.
  - This cycle clears the cache's miss latch.
- Non-owner cache strobes are always 0.
- Address arithmetic is ADDR_WIDTH bits, modulo 2^ADDR_WIDTH. base + 14 never carries out of the block because base[3:0] = 0.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - State: IDLE.
  - Counters: 0.
  - last_grant: D, so the first simultaneous miss grants I.
  - All outputs 0, including fill_addr, memory_address and owner_is_d.
- Reset mid-fill: abandons the fill and commits no tag. In-flight memory returns arriving in IDLE are ignored (no data_wr).
- Cycle t: miss seen in IDLE. Cycles t+1..t+8: memory_enable = 1.
- With a memory latency of L cycles, data_wr pulses fall in cycles t+1+L .. t+8+L. COMMIT is the cycle after the 8th valid, and IDLE follows it.
- For L = 4, total is 14 cycles from the grant cycle to the write_tag_array cycle inclusive.
- memory_data_valid gaps are tolerated: rx_cnt only advances on valid.
- Valid while rx_cnt = 8, in COMMIT, or in IDLE: ignored.
- Owner miss dropping mid-fill: the fill completes regardless. The non-owner miss is held pending, with no action until IDLE.
- A miss request is sampled only in IDLE. The earliest next grant is the cycle after COMMIT.
- Outputs are registered state decode except fill_data and the data_wr strobes, which are combinational from memory_data_valid/memory_data_in.

## Test plan
- Reset hold → all outputs 0; memory_data_valid pulses while in reset or IDLE → no data_wr.
- D miss at 0x1236 alone, L = 4 → memory_address 0x1230, 0x1232 … 0x123E on 8 consecutive cycles; d_data_wr on 8 cycles with fill_addr 0x1230..0x123E; d_write_tag_array 1 cycle with fill_addr 0x1230, 14 cycles after the grant; i_* strobes stay 0.
- I and D miss in the same cycle after reset → I served first (base from icache_miss_addr). D is granted the cycle after I's COMMIT. Then both misses high again → I granted again (alternation).
- Memory valid with gaps (8 valids spread over 20 cycles) → exactly 8 data_wr with ascending fill_addr; COMMIT is the cycle after the 8th valid.
- rst_n low after the 3rd received word → IDLE next cycle; no write_tag_array; later valids ignored; a new miss afterwards restarts at word 0.
- Miss at 0xFFF8 → memory_address wraps within the block: 0xFFF0..0xFFFE; no carry into the tag bits.
